// File: rtl/prbs16_galois_checker.sv
// Receive-side checker for the 16-bit Galois PRBS stream (s[n] = s[n-16]^s[n-3]^s[n-2]).
// Self-synchronises from any point of the stream, declares lock, then counts checked bits
// and bit errors. Lock is dropped when one loss window collects too many errors.
module prbs16_galois_checker #(
   parameter int unsigned LOCK_N   = 32,
   parameter int unsigned WIN_LEN  = 256,
   parameter int unsigned LOSS_ERR = 8,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic             clr_cnt,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] bit_cnt
);

   localparam int unsigned GW = $clog2(LOCK_N + 1);
   localparam int unsigned PW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
   localparam int unsigned EW = $clog2(LOSS_ERR + 1);

   localparam logic [GW-1:0] GOOD_LOCK = GW'(LOCK_N);
   localparam logic [PW-1:0] POS_LAST  = PW'(WIN_LEN - 1);
   localparam logic [EW-1:0] ERR_LOSS  = EW'(LOSS_ERR);

   typedef enum logic [1:0] {
      FILL,
      CHECK,
      LOCKED
   } state_t;

   state_t           state, state_nxt;
   logic [15:0]      hist, hist_nxt, hist_in;
   logic [3:0]       fill_cnt, fill_nxt;
   logic [GW-1:0]    good_cnt, good_nxt;
   logic [PW-1:0]    win_pos, win_pos_nxt;
   logic [EW-1:0]    win_err, win_err_nxt, win_err_base;
   logic [CNT_W-1:0] err_cnt_nxt, bit_cnt_nxt;
   logic             err_pulse_nxt;
   logic             pred, mism;

   // hist[0] is the newest bit; prediction taps follow the stream recurrence
   assign pred    = hist[15] ^ hist[2] ^ hist[1];
   assign mism    = in_bit ^ pred;
   assign hist_in = {hist[14:0], in_bit};
   assign locked  = (state == LOCKED);

   // Next-state and datapath: only accepted bits advance anything; clr_cnt overrides increments
   always_comb begin
      state_nxt     = state;
      hist_nxt      = hist;
      fill_nxt      = fill_cnt;
      good_nxt      = good_cnt;
      win_pos_nxt   = win_pos;
      win_err_nxt   = win_err;
      win_err_base  = '0;
      err_cnt_nxt   = err_cnt;
      bit_cnt_nxt   = bit_cnt;
      err_pulse_nxt = 1'b0;

      if (in_valid) begin
         case (state)
            FILL: begin
               hist_nxt = hist_in;
               if (fill_cnt == 4'd15) begin
                  fill_nxt = '0;
                  if (hist_in != '0) begin
                     state_nxt = CHECK;
                     good_nxt  = '0;
                  end
               end else begin
                  fill_nxt = fill_cnt + 4'd1;
               end
            end

            CHECK: begin
               hist_nxt = hist_in;
               if (hist_in == '0) begin
                  state_nxt = FILL;
                  good_nxt  = '0;
                  fill_nxt  = '0;
               end else if (mism) begin
                  good_nxt = '0;
               end else begin
                  good_nxt = good_cnt + GW'(1);
                  if (good_nxt == GOOD_LOCK) begin
                     state_nxt   = LOCKED;
                     win_pos_nxt = '0;
                     win_err_nxt = '0;
                  end
               end
            end

            LOCKED: begin
               // Flywheel: shift in the prediction so a channel error cannot propagate
               hist_nxt = {hist[14:0], pred};
               if (bit_cnt != '1) bit_cnt_nxt = bit_cnt + CNT_W'(1);
               // The bit that wraps the window position belongs to the new window
               if (win_pos == POS_LAST) begin
                  win_pos_nxt  = '0;
                  win_err_base = '0;
               end else begin
                  win_pos_nxt  = win_pos + PW'(1);
                  win_err_base = win_err;
               end
               win_err_nxt = win_err_base;
               if (mism) begin
                  err_pulse_nxt = 1'b1;
                  if (err_cnt != '1) err_cnt_nxt = err_cnt + CNT_W'(1);
                  win_err_nxt = win_err_base + EW'(1);
                  if (win_err_nxt == ERR_LOSS) begin
                     state_nxt   = FILL;
                     hist_nxt    = '0;
                     fill_nxt    = '0;
                     good_nxt    = '0;
                     win_pos_nxt = '0;
                     win_err_nxt = '0;
                  end
               end
            end

            default: state_nxt = FILL;
         endcase
      end

      if (clr_cnt) begin
         err_cnt_nxt = '0;
         bit_cnt_nxt = '0;
      end
   end

   // State register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FILL;
         hist      <= '0;
         fill_cnt  <= '0;
         good_cnt  <= '0;
         win_pos   <= '0;
         win_err   <= '0;
         err_cnt   <= '0;
         bit_cnt   <= '0;
         err_pulse <= 1'b0;
      end else begin
         state     <= state_nxt;
         hist      <= hist_nxt;
         fill_cnt  <= fill_nxt;
         good_cnt  <= good_nxt;
         win_pos   <= win_pos_nxt;
         win_err   <= win_err_nxt;
         err_cnt   <= err_cnt_nxt;
         bit_cnt   <= bit_cnt_nxt;
         err_pulse <= err_pulse_nxt;
      end
   end

endmodule

// File: tb/tb_prbs16_galois_checker.sv
// Scoreboard bench for prbs16_galois_checker: directed scenarios push expected outputs per
// cycle into a queue; a negedge monitor pops and compares them against the DUT.
module tb_prbs16_galois_checker;

   localparam int unsigned CNT_W = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_bit = 1'b0;
   logic             clr_cnt = 1'b0;
   logic             locked, err_pulse;
   logic [CNT_W-1:0] err_cnt, bit_cnt;

   prbs16_galois_checker #(
      .LOCK_N  (32),
      .WIN_LEN (256),
      .LOSS_ERR(8),
      .CNT_W   (CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_bit   (in_bit),
      .clr_cnt  (clr_cnt),
      .locked   (locked),
      .err_pulse(err_pulse),
      .err_cnt  (err_cnt),
      .bit_cnt  (bit_cnt)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef enum int {F_LOCKED, F_PULSE, F_ERRCNT, F_BITCNT} fld_t;
   typedef struct {
      int unsigned cyc;
      fld_t        fld;
      logic [31:0] exp;
      string       tag;
   } item_t;

   item_t sb[$];
   int    n_cmp = 0;
   int    n_bad = 0;
   string phase = "init";

   function automatic logic [31:0] actual(fld_t f);
      case (f)
         F_LOCKED: return 32'(locked);
         F_PULSE:  return 32'(err_pulse);
         F_ERRCNT: return 32'(err_cnt);
         default:  return 32'(bit_cnt);
      endcase
   endfunction

   function automatic string fname(fld_t f);
      case (f)
         F_LOCKED: return "locked";
         F_PULSE:  return "err_pulse";
         F_ERRCNT: return "err_cnt";
         default:  return "bit_cnt";
      endcase
   endfunction

   // Monitor: compare every expectation due at this cycle
   always @(negedge clk) begin
      item_t       it;
      logic [31:0] act;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         it  = sb.pop_front();
         act = actual(it.fld);
         n_cmp++;
         if (it.cyc != cyc) begin
            n_bad++;
            $display("FAIL %s %s: expectation for cycle %0d sampled late at %0d",
                     it.tag, fname(it.fld), it.cyc, cyc);
         end else if (act !== it.exp) begin
            n_bad++;
            $display("FAIL %s %s @cycle %0d: got %0d, expected %0d",
                     it.tag, fname(it.fld), cyc, act, it.exp);
         end
      end
   end

   // Reference stream: first 16 bits are the seed bits (LSB first), then the recurrence
   logic [15:0] gh = '0;
   int unsigned gn = 0;

   function automatic logic gen_bit();
      logic [15:0] s;
      logic        b;
      s = 16'hA2C1;
      if (gn < 16) b = s[gn[3:0]];
      else         b = gh[15] ^ gh[2] ^ gh[1];
      gh = {gh[14:0], b};
      gn++;
      return b;
   endfunction

   // Expected-behaviour bookkeeping driven by the scenarios
   bit          m_lk = 1'b0;
   bit          stream_ok = 1'b1;
   int unsigned m_vcnt = 0;
   int unsigned m_bits = 0;
   int unsigned m_errs = 0;
   int unsigned lkpos = 0;

   task automatic push(input fld_t f, input logic [31:0] e);
      item_t it;
      it.cyc = cyc;
      it.fld = f;
      it.exp = e;
      it.tag = phase;
      sb.push_back(it);
   endtask

   // One clock: drive inputs, then queue the expected outputs after this edge.
   // lose marks the bit the scenario expects to trigger loss of lock.
   task automatic step(input logic r, input logic v, input logic b, input logic flip,
                       input logic clr, input logic lose);
      logic ep;
      rst      = r;
      in_valid = v;
      in_bit   = b ^ flip;
      clr_cnt  = clr;
      @(posedge clk);
      #1;
      ep = 1'b0;
      if (r) begin
         m_lk   = 1'b0;
         m_vcnt = 0;
         m_bits = 0;
         m_errs = 0;
      end else if (v) begin
         if (m_lk) begin
            m_bits++;
            lkpos++;
            if (flip) begin
               m_errs++;
               ep = 1'b1;
            end
            if (lose) begin
               m_lk   = 1'b0;
               m_vcnt = 0;
            end
         end else begin
            m_vcnt++;
            if (stream_ok && m_vcnt == 48) begin
               m_lk  = 1'b1;
               lkpos = 0;
            end
         end
      end
      if (clr && !r) begin
         m_bits = 0;
         m_errs = 0;
      end
      push(F_LOCKED, 32'(m_lk));
      push(F_PULSE,  32'(ep));
      push(F_ERRCNT, m_errs);
      push(F_BITCNT, m_bits);
   endtask

   task automatic good_bits(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b1, gen_bit(), 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      logic rb;
      rb = 1'($urandom_range(0, 1));
      step(1'b1, 1'b1, rb, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int unsigned w;
      int unsigned p;
      logic        f;
      logic        l;
      logic        v;
      logic        rb;
      bit          done;

      phase = "reset";
      do_reset();
      do_reset();

      phase = "lock";
      good_bits(10000);

      phase = "single_err";
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, gen_bit(), 1'b1, 1'b0, 1'b0);
      good_bits(20);

      phase = "split_4_4";
      w = ((lkpos + 32) / 256 + 1) * 256;
      while (lkpos <= w + 30) begin
         p = lkpos;
         f = (p >= w - 16 && p <= w - 10 && ((p - (w - 16)) % 2) == 0) ||
             (p >= w + 10 && p <= w + 16 && ((p - (w + 10)) % 2) == 0);
         step(1'b0, 1'b1, gen_bit(), f, 1'b0, 1'b0);
      end

      phase = "loss_8";
      w = ((lkpos + 32) / 256 + 1) * 256;
      done = 1'b0;
      while (!done) begin
         p = lkpos;
         f = (p >= w + 20) && (((p - (w + 20)) % 2) == 0);
         l = f && (p == w + 34);
         step(1'b0, 1'b1, gen_bit(), f, 1'b0, l);
         done = l;
      end

      phase = "relock";
      good_bits(60);

      phase = "zeros";
      stream_ok = 1'b0;
      do_reset();
      for (int unsigned i = 0; i < 200; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      stream_ok = 1'b1;

      phase = "valid_50";
      do_reset();
      for (int unsigned i = 0; i < 400; i++) begin
         if (i == 250) begin
            step(1'b0, 1'b1, gen_bit(), 1'b0, 1'b1, 1'b0);
         end else begin
            v = 1'($urandom_range(0, 1));
            if (v) begin
               step(1'b0, 1'b1, gen_bit(), 1'b0, 1'b0, 1'b0);
            end else begin
               rb = 1'($urandom_range(0, 1));
               step(1'b0, 1'b0, rb, 1'b0, 1'b0, 1'b0);
            end
         end
      end

      phase = "rst_check";
      do_reset();
      good_bits(30);
      step(1'b1, 1'b1, gen_bit(), 1'b0, 1'b0, 1'b0);
      good_bits(50);

      phase = "rst_locked";
      good_bits(9);
      step(1'b0, 1'b1, gen_bit(), 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, gen_bit(), 1'b0, 1'b0, 1'b0);
      good_bits(50);

      phase = "idle";
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
         n_bad += sb.size();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
